iob_cache_be_arbiter: RTL and testbench

Round-robin arbiter that shares one IOb native back-end port (memory controller or next-level cache) between N cache back-ends, e.g. separate instruction and data caches. Sits between the `be_*` ports of several cache instances and a single memory port. Each granted transaction is latched at grant time, so the shared port sees a stable request until it acknowledges. Requesters are served in strict rotation, one transaction at a time.

---
 rtl/iob_cache_be_arbiter_pkg.sv | 17 +
 rtl/iob_cache_be_arbiter_rr_prio.sv | 40 ++++
 rtl/iob_cache_be_arbiter.sv | 103 ++++++++++
 tb/tb_iob_cache_be_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_be_arbiter_pkg.sv
// ============================================================================
// Module   : iob_cache_be_arbiter_pkg
// Brief    : Shared types for the cache back-end round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_cache_be_arbiter_pkg;

  typedef enum logic [0:0] {
    IOB_CACHE_ARB_IDLE = 1'b0,
    IOB_CACHE_ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/iob_cache_be_arbiter_rr_prio.sv
// ============================================================================
// Module   : iob_cache_be_arbiter_rr_prio
// Brief    : Combinational round-robin priority encoder (rotate + find-first).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_cache_be_arbiter_rr_prio #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam logic [W:0] c_n = (W+1)'(N);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;
  logic [W:0]   w_sum;

  // Rotating the doubled vector puts the requester at ptr in bit 0.
  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = W'(i);
    end
  end

  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign idx   = (w_sum >= c_n) ? W'(w_sum - c_n) : w_sum[W-1:0];
  assign any   = |req;

endmodule

`default_nettype wire

// File: rtl/iob_cache_be_arbiter.sv
// ============================================================================
// Module   : iob_cache_be_arbiter
// Brief    : Round-robin arbiter sharing one IOb back-end port among N caches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_cache_be_arbiter
  import iob_cache_be_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ack,
  output logic                            s_req,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ack,
  output logic [$clog2(N_MASTERS)-1:0]    grant,
  output logic                            busy
);

  localparam int c_gnt_w  = $clog2(N_MASTERS);
  localparam int c_strb_w = DATA_W / 8;
  localparam logic [c_gnt_w-1:0] c_last = c_gnt_w'(N_MASTERS - 1);

  arb_state_t           r_state;
  logic [c_gnt_w-1:0]   r_ptr;
  logic [c_gnt_w-1:0]   r_grant;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [c_strb_w-1:0]  r_wstrb;

  logic [c_gnt_w-1:0]   w_idx;
  logic                 w_any;

  iob_cache_be_arbiter_rr_prio #(
    .N (N_MASTERS),
    .W (c_gnt_w)
  ) u_rr_prio (
    .req (m_req),
    .ptr (r_ptr),
    .idx (w_idx),
    .any (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IOB_CACHE_ARB_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      case (r_state)
        IOB_CACHE_ARB_IDLE: begin
          if (w_any) begin
            r_state <= IOB_CACHE_ARB_BUSY;
            r_grant <= w_idx;
            r_addr  <= m_addr [w_idx*ADDR_W   +: ADDR_W];
            r_wdata <= m_wdata[w_idx*DATA_W   +: DATA_W];
            r_wstrb <= m_wstrb[w_idx*c_strb_w +: c_strb_w];
          end
        end
        IOB_CACHE_ARB_BUSY: begin
          // Requester inputs are ignored here; only the slave ack matters.
          if (s_ack) begin
            r_state <= IOB_CACHE_ARB_IDLE;
            r_ptr   <= (r_grant == c_last) ? '0 : r_grant + 1'b1;
          end
        end
        default: r_state <= IOB_CACHE_ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    m_ack = '0;
    if ((r_state == IOB_CACHE_ARB_BUSY) && s_ack) m_ack[r_grant] = 1'b1;
  end

  assign s_req   = (r_state == IOB_CACHE_ARB_BUSY);
  assign busy    = s_req;
  assign grant   = r_grant;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;
  assign s_wstrb = r_wstrb;
  assign m_rdata = s_rdata;

endmodule

`default_nettype wire

// File: tb/tb_iob_cache_be_arbiter.sv
// ============================================================================
// Module   : tb_iob_cache_be_arbiter
// Brief    : Directed, table-driven bench for the 4-requester arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_cache_be_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ack;
  logic            s_req;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ack;
  logic [GW-1:0]   grant;
  logic            busy;

  iob_cache_be_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .s_req   (s_req),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  req;
    logic          ack_in;
    logic          exp_sreq;
    logic [GW-1:0] exp_grant;
    logic [N-1:0]  exp_ack;
  } vec_t;

  vec_t vecs [21];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {req, s_ack, exp s_req/busy, exp grant, exp m_ack}
    vecs[0]  = '{4'hF, 1'b1, 1'b0, 2'd0, 4'h0};
    vecs[1]  = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1};
    vecs[2]  = '{4'hF, 1'b1, 1'b0, 2'd0, 4'h0};
    vecs[3]  = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2};
    vecs[4]  = '{4'hF, 1'b1, 1'b0, 2'd1, 4'h0};
    vecs[5]  = '{4'hF, 1'b1, 1'b1, 2'd2, 4'h4};
    vecs[6]  = '{4'hF, 1'b1, 1'b0, 2'd2, 4'h0};
    vecs[7]  = '{4'hF, 1'b1, 1'b1, 2'd3, 4'h8};
    vecs[8]  = '{4'hF, 1'b1, 1'b0, 2'd3, 4'h0};
    vecs[9]  = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1};
    vecs[10] = '{4'h1, 1'b1, 1'b0, 2'd0, 4'h0};
    vecs[11] = '{4'h1, 1'b1, 1'b1, 2'd0, 4'h1};
    vecs[12] = '{4'h9, 1'b0, 1'b0, 2'd0, 4'h0};
    vecs[13] = '{4'h9, 1'b0, 1'b1, 2'd3, 4'h0};
    vecs[14] = '{4'h0, 1'b1, 1'b1, 2'd3, 4'h8};
    vecs[15] = '{4'h0, 1'b1, 1'b0, 2'd3, 4'h0};
    vecs[16] = '{4'h0, 1'b1, 1'b0, 2'd3, 4'h0};
    vecs[17] = '{4'h6, 1'b0, 1'b0, 2'd3, 4'h0};
    vecs[18] = '{4'h6, 1'b1, 1'b1, 2'd1, 4'h2};
    vecs[19] = '{4'h6, 1'b0, 1'b0, 2'd1, 4'h0};
    vecs[20] = '{4'h6, 1'b0, 1'b1, 2'd2, 4'h0};

    rst     = 1'b0;
    m_req   = '1;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = '0;
    s_ack   = 1'b1;

    // Held in reset with everyone requesting: nothing may be issued.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_sreq", 64'(s_req), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_mack", 64'(m_ack), 64'(0));
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_saddr", 64'(s_addr), 64'(0));
    end

    for (int i = 0; i < N; i++) m_addr[i*AW +: AW] = 32'h100 * (i + 1);
    s_ack = 1'b0;
    rst   = 1'b1;

    for (int v = 0; v < 21; v++) begin
      m_req = vecs[v].req;
      s_ack = vecs[v].ack_in;
      #1;
      chk($sformatf("v%0d_sreq", v), 64'(s_req), 64'(vecs[v].exp_sreq));
      chk($sformatf("v%0d_busy", v), 64'(busy), 64'(vecs[v].exp_sreq));
      chk($sformatf("v%0d_grant", v), 64'(grant), 64'(vecs[v].exp_grant));
      chk($sformatf("v%0d_mack", v), 64'(m_ack), 64'(vecs[v].exp_ack));
      if (vecs[v].exp_sreq)
        chk($sformatf("v%0d_saddr", v), 64'(s_addr),
            64'(32'h100 * (32'(vecs[v].exp_grant) + 1)));
      @(posedge clk);
      #1;
    end

    // Reset while BUSY with grant 2: outputs clear without waiting for a clock.
    chk("pre_rst_grant", 64'(grant), 64'(2));
    s_ack = 1'b1;
    rst   = 1'b0;
    #1;
    chk("midrst_sreq", 64'(s_req), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_grant", 64'(grant), 64'(0));
    chk("midrst_mack", 64'(m_ack), 64'(0));
    chk("midrst_saddr", 64'(s_addr), 64'(0));
    s_ack = 1'b0;
    m_req = 4'b0111;
    #2;
    rst = 1'b1;
    tick();
    chk("postrst_grant", 64'(grant), 64'(0));
    chk("postrst_sreq", 64'(s_req), 64'(1));
    m_req = '0;
    s_ack = 1'b1;
    #1;
    chk("postrst_mack", 64'(m_ack), 64'(1));
    tick();
    s_ack = 1'b0;
    chk("postrst_idle", 64'(s_req), 64'(0));

    // Single read by requester 0, slave acks on the fourth BUSY cycle.
    m_addr[0 +: AW] = 32'h1000;
    m_wstrb[0 +: SW] = '0;
    m_req = 4'b0001;
    tick();
    chk("rd_sreq", 64'(s_req), 64'(1));
    chk("rd_grant", 64'(grant), 64'(0));
    m_req = '0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd_wait%0d_saddr", k), 64'(s_addr), 64'(32'h1000));
      chk($sformatf("rd_wait%0d_mack", k), 64'(m_ack), 64'(0));
      tick();
    end
    s_ack   = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    #1;
    chk("rd_ack_mack", 64'(m_ack), 64'(1));
    chk("rd_ack_rdata", 64'(m_rdata), 64'(32'hCAFE_F00D));
    chk("rd_ack_saddr", 64'(s_addr), 64'(32'h1000));
    chk("rd_ack_wstrb", 64'(s_wstrb), 64'(0));
    tick();
    s_ack   = 1'b0;
    s_rdata = '0;
    #1;
    chk("rd_done_sreq", 64'(s_req), 64'(0));
    chk("rd_done_mack", 64'(m_ack), 64'(0));

    // Requester 1 changes its inputs after grant; the latched request holds.
    m_addr [1*AW +: AW] = 32'h20;
    m_wdata[1*DW +: DW] = 32'h1234_5678;
    m_wstrb[1*SW +: SW] = 4'hF;
    m_req = 4'b0010;
    tick();
    chk("stab_grant", 64'(grant), 64'(1));
    chk("stab_sreq", 64'(s_req), 64'(1));
    m_addr [1*AW +: AW] = 32'h40;
    m_wdata[1*DW +: DW] = 32'h0;
    m_wstrb[1*SW +: SW] = 4'h0;
    m_req = '0;
    tick();
    chk("stab_saddr", 64'(s_addr), 64'(32'h20));
    chk("stab_wdata", 64'(s_wdata), 64'(32'h1234_5678));
    chk("stab_wstrb", 64'(s_wstrb), 64'(4'hF));
    s_ack = 1'b1;
    #1;
    chk("stab_mack", 64'(m_ack), 64'(2));
    tick();
    s_ack = 1'b0;
    chk("stab_idle", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
